// File: rtl/des_iter_engine.sv
// Iterative DES/TDES datapath: IP on load, UNROLL Feistel rounds per clock from
// external subkeys, FP once after the final pass, result held under valid/ready.
module des_iter_engine #(
  parameter int UNROLL = 1,
  parameter int PASSES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_data,
  input  logic [48*UNROLL-1:0]   keys,
  output logic [4:0]             key_round,
  output logic [1:0]             key_pass,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_data,
  output logic                   busy
);

  localparam int CPP = 16 / UNROLL;
  localparam int N   = CPP * PASSES;
  localparam int CW  = $clog2(N + 1);

  if (!(PASSES == 1 || PASSES == 3)) begin : g_bad_passes
    $error("des_iter_engine: PASSES must be 1 or 3");
  end
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
    $error("des_iter_engine: UNROLL must be 1, 2, 4, 8 or 16");
  end

  // Tables use DES bit numbering: entry value k means source bit k, bit 1 = MSB.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  // Each S-box is 64 nibbles, entry (row*16+col) counted from the MSB end.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  function automatic logic [63:0] perm64(input logic [63:0] d, input logic fwd);
    logic [63:0] o;
    for (int k = 0; k < 64; k++) o[63-k] = d[64 - (fwd ? IP_T[k] : FP_T[k])];
    return o;
  endfunction

  function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, p;
    logic [5:0]  b, idx;
    for (int i = 0; i < 48; i++) x[47-i] = r[32 - E_T[i]];
    x = x ^ k;
    for (int i = 0; i < 8; i++) begin
      b   = x[47-6*i -: 6];
      idx = {b[5], b[0], b[4:1]};
      s[31-4*i -: 4] = SBOX[i][255 - 4*int'(idx) -: 4];
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32 - P_T[i]];
    return p;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_l, r_r;
  logic [31:0]     w_l [UNROLL+1];
  logic [31:0]     w_r [UNROLL+1];
  logic [63:0]     w_ip;
  logic            w_pass_end, w_load;
  int              w_phase;

  assign w_phase    = int'(r_cnt) % CPP;
  assign w_pass_end = (w_phase == CPP - 1);
  assign w_ip       = perm64(in_data, 1'b1);
  assign w_load     = in_valid && in_ready;

  always_comb begin
    w_l[0] = r_l;
    w_r[0] = r_r;
    for (int j = 0; j < UNROLL; j++) begin
      w_l[j+1] = w_r[j];
      w_r[j+1] = w_l[j] ^ f_fn(w_r[j], keys[48*j +: 48]);
    end
  end

  assign in_ready  = (r_state == IDLE) || (r_state == DONE && out_ready);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_data  = (r_state == DONE) ? perm64({r_l, r_r}, 1'b0) : 64'd0;
  assign key_round = (r_state == RUN) ? 5'(w_phase * UNROLL) : 5'd0;
  assign key_pass  = (r_state == RUN) ? 2'(int'(r_cnt) / CPP) : 2'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_l     <= '0;
      r_r     <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_load) begin
          {r_l, r_r} <= w_ip;
          r_cnt      <= '0;
          r_state    <= RUN;
        end
        RUN: begin
          // Pass end stores (R16, L16); FP of the next pass and IP cancel out.
          if (w_pass_end) {r_l, r_r} <= {w_r[UNROLL], w_l[UNROLL]};
          else            {r_l, r_r} <= {w_l[UNROLL], w_r[UNROLL]};
          if (r_cnt == CW'(N - 1)) begin
            r_cnt   <= '0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          if (in_valid) begin
            {r_l, r_r} <= w_ip;
            r_cnt      <= '0;
            r_state    <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_iter_engine.sv
// Directed bench: DES/TDES known-answer vectors across unroll factors, handshake,
// backpressure, back-to-back load and mid-run reset.
module tb_des_iter_engine;

  localparam logic [63:0] PT = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT = 64'h85E813540F0AB405;
  // Subkeys K1..K16 of key 133457799BBCDFF1.
  localparam logic [47:0] SK [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  logic        clk = 1'b0;
  logic        reset;
  logic        dec;
  logic [4:0]  in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] in_data  [5];
  logic [63:0] out_data [5];
  logic [767:0] keys    [5];
  logic [4:0]  key_round [5];
  logic [1:0]  key_pass  [5];
  int          nerr = 0;
  int          nchk = 0;

  always #5 clk = ~clk;

  // EDE schedule: pass 1 runs the reverse order; dec flips every pass.
  function automatic logic [767:0] ks(input logic [4:0] kr, input logic [1:0] kp,
                                      input int un, input logic d);
    logic [767:0] v;
    int r, idx;
    logic enc;
    v = '0;
    for (int j = 0; j < un; j++) begin
      r   = int'(kr) + j;
      enc = !(d ^ (kp == 2'd1));
      idx = enc ? r : 15 - r;
      if (idx >= 0 && idx < 16) v[48*j +: 48] = SK[idx];
    end
    return v;
  endfunction

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int UN = (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 16 : 1;
    localparam int PA = (g == 4) ? 3 : 1;
    assign keys[g] = ks(key_round[g], key_pass[g], UN, dec);
    des_iter_engine #(.UNROLL(UN), .PASSES(PA)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .keys      (keys[g][48*UN-1:0]),
      .key_round (key_round[g]),
      .key_pass  (key_pass[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Call right after the accept edge; follows the block to DONE.
  task automatic measure(input int idx, input int un, input int np,
                         input logic [63:0] exp, input string tag);
    int c, cpp;
    bit seen;
    cpp  = 16 / un;
    c    = 0;
    seen = 0;
    while (!seen && c < 200) begin
      @(negedge clk);
      in_valid[idx]  = 1'b0;
      out_ready[idx] = 1'b0;
      if (out_valid[idx]) seen = 1;
      else begin
        chk({tag, " kround"}, 64'(key_round[idx]), 64'((c % cpp) * un));
        chk({tag, " kpass"},  64'(key_pass[idx]),  64'(c / cpp));
        c++;
      end
    end
    chk({tag, " latency"}, 64'(c), 64'(cpp * np));
    chk({tag, " data"},    out_data[idx], exp);
    chk({tag, " busy"},    64'(busy[idx]), 64'd1);
    chk({tag, " inrdy"},   64'(in_ready[idx]), 64'd0);
  endtask

  task automatic release_out(input int idx, input string tag);
    out_ready[idx] = 1'b1;
    @(negedge clk);
    out_ready[idx] = 1'b0;
    chk({tag, " idle ov"},  64'(out_valid[idx]), 64'd0);
    chk({tag, " idle rdy"}, 64'(in_ready[idx]),  64'd1);
    chk({tag, " idle bsy"}, 64'(busy[idx]),      64'd0);
  endtask

  task automatic run(input int idx, input int un, input int np,
                     input logic [63:0] din, input logic [63:0] exp, input string tag);
    chk({tag, " rdy"}, 64'(in_ready[idx]), 64'd1);
    in_valid[idx] = 1'b1;
    in_data[idx]  = din;
    @(posedge clk);
    measure(idx, un, np, exp, tag);
    release_out(idx, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    dec       = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < 5; i++) in_data[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i += 4) begin
      chk("rst in_ready",  64'(in_ready[i]),  64'd1);
      chk("rst out_valid", 64'(out_valid[i]), 64'd0);
      chk("rst out_data",  out_data[i],       64'd0);
      chk("rst busy",      64'(busy[i]),      64'd0);
      chk("rst key_round", 64'(key_round[i]), 64'd0);
      chk("rst key_pass",  64'(key_pass[i]),  64'd0);
    end

    run(0, 1, 1, PT, CT, "des");
    dec = 1'b1;
    run(0, 1, 1, CT, PT, "des dec");
    dec = 1'b0;
    run(1, 2, 1, PT, CT, "u2");
    run(2, 4, 1, PT, CT, "u4");
    run(3, 16, 1, PT, CT, "u16");
    run(4, 1, 3, PT, CT, "tdes");

    // Stall in DONE, then release together with a new block.
    in_valid[0] = 1'b1;
    in_data[0]  = PT;
    @(posedge clk);
    measure(0, 1, 1, CT, "bp");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall data",  out_data[0],         CT);
      chk("stall inrdy", 64'(in_ready[0]),    64'd0);
      chk("stall valid", 64'(out_valid[0]),   64'd1);
    end
    dec         = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = CT;
    out_ready[0] = 1'b1;
    #1;
    chk("b2b inrdy", 64'(in_ready[0]), 64'd1);
    @(posedge clk);
    measure(0, 1, 1, PT, "b2b");
    release_out(0, "b2b");
    dec = 1'b0;

    // Reset while round 7 is in flight.
    in_valid[0] = 1'b1;
    in_data[0]  = PT;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid[0] = 1'b0;
    end
    chk("mid kround", 64'(key_round[0]), 64'd7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort inrdy", 64'(in_ready[0]),  64'd1);
    chk("abort ov",    64'(out_valid[0]), 64'd0);
    chk("abort busy",  64'(busy[0]),      64'd0);
    chk("abort data",  out_data[0],       64'd0);
    run(0, 1, 1, PT, CT, "fresh");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
